// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg -- shared definitions for the Hack data-memory block.
//   * CPU address map constants (region base/limit values)
//   * region_e    : decoded region of a CPU address
//   * scr_state_e : display read-port FSM state
//   * decode_region() : maps a CPU address to its region
package hack_mem_pkg;

  localparam int unsigned RAM_BASE     = 32'h0000_0000;
  localparam int unsigned RAM_LIMIT    = 32'h0000_3FFF;
  localparam int unsigned SCREEN_BASE  = 32'h0000_4000;
  localparam int unsigned SCREEN_LIMIT = 32'h0000_5FFF;
  localparam int unsigned KBD_ADDR     = 32'h0000_6000;

  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int RAM_AW       = 14;
  localparam int SCREEN_AW    = 13;

  typedef enum logic [1:0] {
    REGION_RAM     = 2'd0,
    REGION_SCREEN  = 2'd1,
    REGION_KBD     = 2'd2,
    REGION_ILLEGAL = 2'd3
  } region_e;

  typedef enum logic [0:0] {
    SCR_IDLE = 1'b0,
    SCR_BUSY = 1'b1
  } scr_state_e;

  // RAM starts at address zero, so only its upper limit needs a compare.
  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr <= RAM_LIMIT) begin
      return REGION_RAM;
    end else if (addr >= SCREEN_BASE && addr <= SCREEN_LIMIT) begin
      return REGION_SCREEN;
    end else if (addr == KBD_ADDR) begin
      return REGION_KBD;
    end else begin
      return REGION_ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/hack_memory_if.sv
// hack_memory_if -- bundle of the CPU bus, keyboard handshake and display
// read port of hack_memory, plus debug observation signals.
//
// Handshakes:
//   keyboard : a keycode is pushed on a rising clk edge where
//              kbd_valid_in=1 and kbd_ready_out=1; with kbd_ready_out=0 the
//              offer is simply not taken that cycle.
//   display  : scr_req_in=1 while the port is idle captures scr_addr_in;
//              the following cycle scr_ack_out=1 for exactly one cycle with
//              scr_data_out valid. Requests while busy are ignored.
//
// Modports:
//   slave  : the memory block (hack_memory)
//   master : the CPU / keyboard / display side driving it
// Debug:
//   dbg_scr_state : display FSM state
//   dbg_kbd_count : number of keycodes held in the keyboard buffer
interface hack_memory_if
  import hack_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int KBD_DEPTH     = 4
);
  localparam int COUNT_W = $clog2(KBD_DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     write_in;
  logic [DATA_WIDTH-1:0]    data_out;

  logic                     kbd_valid_in;
  logic [DATA_WIDTH-1:0]    kbd_code_in;
  logic                     kbd_ready_out;

  logic                     scr_req_in;
  logic [12:0]              scr_addr_in;
  logic                     scr_ack_out;
  logic [DATA_WIDTH-1:0]    scr_data_out;

  logic                     addr_err_out;

  scr_state_e               dbg_scr_state;
  logic [COUNT_W-1:0]       dbg_kbd_count;

  modport slave (
    input  addr_in, data_in, write_in,
    input  kbd_valid_in, kbd_code_in,
    input  scr_req_in, scr_addr_in,
    output data_out, kbd_ready_out, scr_ack_out, scr_data_out,
    output addr_err_out, dbg_scr_state, dbg_kbd_count
  );

  modport master (
    output addr_in, data_in, write_in,
    output kbd_valid_in, kbd_code_in,
    output scr_req_in, scr_addr_in,
    input  data_out, kbd_ready_out, scr_ack_out, scr_data_out,
    input  addr_err_out, dbg_scr_state, dbg_kbd_count
  );

endinterface

// File: rtl/hack_kbd_fifo.sv
// hack_kbd_fifo -- keyboard keycode buffer.
//   HACK_MEM_KBD_FIFO_EN defined   : KBD_DEPTH-entry circular FIFO
//   HACK_MEM_KBD_FIFO_EN undefined : single holding register with full flag
// Both variants share the same rules: push when push_valid_i && push_ready_o,
// pop on pop_i when not empty (ignored when empty), head_o reads 0 when empty.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_valid_i  : keycode offered
//   push_data_i   : keycode
//   push_ready_o  : buffer not full
//   pop_i         : remove the head entry
//   head_o        : head entry, or 0 when empty
//   count_o       : number of entries held
module hack_kbd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int KBD_DEPTH  = 4,
  parameter int COUNT_W    = $clog2(KBD_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  push_ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [COUNT_W-1:0]    count_o
);

`ifdef HACK_MEM_KBD_FIFO_EN

  localparam int PTR_W = $clog2(KBD_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [KBD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == COUNT_W'(KBD_DEPTH));
  assign empty   = (count_q == '0);
  // On a full buffer a simultaneous pop still goes ahead, but the push is
  // refused because ready is computed from the current count.
  assign do_push = push_valid_i && !full;
  assign do_pop  = pop_i && !empty;

  // Pointers are PTR_W bits wide, so the increment wraps modulo KBD_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign push_ready_o = !full;
  assign head_o       = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o      = count_q;

`else

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  do_push;
  logic                  do_pop;

  // Push only into an empty register, so push and pop never coincide.
  assign do_push = push_valid_i && !full_q;
  assign do_pop  = pop_i && full_q;

  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (do_pop) full_d = 1'b0;
    if (do_push) begin
      full_d = 1'b1;
      hold_d = push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

  assign push_ready_o = !full_q;
  assign head_o       = full_q ? hold_q : '0;
  assign count_o      = COUNT_W'(full_q);

`endif

endmodule

// File: rtl/hack_memory.sv
// hack_memory -- Hack computer data memory: 16K-word RAM, 8K-word screen
// buffer, memory-mapped keyboard buffer and a display read port.
//
// Address map: 0x0000-0x3FFF RAM, 0x4000-0x5FFF SCREEN, 0x6000 KBD,
// everything else ILLEGAL (reads 0, writes dropped, addr_err_out pulses the
// cycle after an illegal write).
//
// Ports:
//   clk  : single clock, all state updates on its rising edge
//   rst  : asynchronous active-high reset (RAM/SCREEN contents kept)
//   bus  : hack_memory_if.slave -- CPU bus (addr_in, data_in, write_in,
//          data_out), keyboard push handshake (kbd_valid_in, kbd_code_in,
//          kbd_ready_out), display port (scr_req_in, scr_addr_in,
//          scr_ack_out, scr_data_out), addr_err_out and debug signals.
//
// Configuration macro: HACK_MEM_KBD_FIFO_EN selects a KBD_DEPTH-entry
// keyboard FIFO; without it the keyboard buffer is one holding register.
module hack_memory
  import hack_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int KBD_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  hack_memory_if.slave bus
);

  localparam int COUNT_W = $clog2(KBD_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram_q    [RAM_WORDS];
  logic [DATA_WIDTH-1:0] screen_q [SCREEN_WORDS];

  logic [31:0]           addr_ext;
  region_e               region;
  logic                  ram_we;
  logic                  screen_we;
  logic                  kbd_pop;
  logic [DATA_WIDTH-1:0] kbd_head;
  logic [COUNT_W-1:0]    kbd_count;
  logic                  kbd_ready;

  scr_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] scr_data_q, scr_data_d;
  logic                  addr_err_q, addr_err_d;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  assign addr_ext  = 32'(bus.addr_in);
  assign region    = decode_region(addr_ext);
  assign ram_we    = bus.write_in && (region == REGION_RAM);
  assign screen_we = bus.write_in && (region == REGION_SCREEN);
  // A write to the keyboard address is a pop request; the data is ignored.
  assign kbd_pop   = bus.write_in && (region == REGION_KBD);

  // ---------------------------------------------------------------------
  // Arrays: written on the clock edge, never reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we)    ram_q[bus.addr_in[RAM_AW-1:0]]       <= bus.data_in;
    if (screen_we) screen_q[bus.addr_in[SCREEN_AW-1:0]] <= bus.data_in;
  end

  // ---------------------------------------------------------------------
  // CPU read mux: zero-latency combinational read
  // ---------------------------------------------------------------------
  always_comb begin
    bus.data_out = '0;
    case (region)
      REGION_RAM:    bus.data_out = ram_q[bus.addr_in[RAM_AW-1:0]];
      REGION_SCREEN: bus.data_out = screen_q[bus.addr_in[SCREEN_AW-1:0]];
      REGION_KBD:    bus.data_out = kbd_head;
      default:       bus.data_out = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Keyboard buffer
  // ---------------------------------------------------------------------
  hack_kbd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .KBD_DEPTH  (KBD_DEPTH),
    .COUNT_W    (COUNT_W)
  ) u_kbd_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (bus.kbd_valid_in),
    .push_data_i  (bus.kbd_code_in),
    .push_ready_o (kbd_ready),
    .pop_i        (kbd_pop),
    .head_o       (kbd_head),
    .count_o      (kbd_count)
  );

  assign bus.kbd_ready_out = kbd_ready;
  assign bus.dbg_kbd_count = kbd_count;

  // ---------------------------------------------------------------------
  // Display read port FSM (IDLE -> BUSY -> IDLE)
  // ---------------------------------------------------------------------
  // The screen word is sampled at the capture edge from the array value
  // before any same-edge CPU write lands, giving read-before-write.
  always_comb begin
    state_d    = state_q;
    scr_data_d = scr_data_q;
    case (state_q)
      SCR_IDLE: begin
        if (bus.scr_req_in) begin
          state_d    = SCR_BUSY;
          scr_data_d = screen_q[bus.scr_addr_in];
        end
      end
      SCR_BUSY: state_d = SCR_IDLE;
      default:  state_d = SCR_IDLE;
    endcase
  end

  assign addr_err_d = bus.write_in && (region == REGION_ILLEGAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCR_IDLE;
      scr_data_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scr_data_q <= scr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Ack is the BUSY state itself, so an asynchronous reset mid-request
  // drops it immediately and no ack is ever produced for that request.
  assign bus.scr_ack_out   = (state_q == SCR_BUSY);
  assign bus.scr_data_out  = scr_data_q;
  assign bus.addr_err_out  = addr_err_q;
  assign bus.dbg_scr_state = state_q;

endmodule

// File: tb/tb_hack_memory.sv
module tb_hack_memory;
  import hack_mem_pkg::*;

`ifdef HACK_MEM_KBD_FIFO_EN
  localparam int EFF_DEPTH = 4;
`else
  localparam int EFF_DEPTH = 1;
`endif

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hack_memory_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .KBD_DEPTH(4)) bus ();

  hack_memory #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .KBD_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic drive_cpu(input logic [15:0] addr, input logic [15:0] wdata, input logic wr);
    bus.addr_in  = addr;
    bus.data_in  = wdata;
    bus.write_in = wr;
  endtask

  task automatic drive_kbd(input logic kv, input logic [15:0] kc);
    bus.kbd_valid_in = kv;
    bus.kbd_code_in  = kc;
  endtask

  task automatic drive_scr(input logic req, input logic [12:0] idx);
    bus.scr_req_in  = req;
    bus.scr_addr_in = idx;
  endtask

  // ---------------------------------------------------------------------
  // Vector table: inputs applied for one cycle, outputs checked before
  // the edge that consumes them.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        kv;
    logic [15:0] kc;
    logic        chk_dout;
    logic [15:0] exp_dout;
    logic        exp_ready;
    int          exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [15:0] addr, input logic [15:0] wdata, input logic wr,
                         input logic kv, input logic [15:0] kc, input logic chk_dout,
                         input logic [15:0] exp_dout, input logic exp_ready,
                         input int exp_count, input logic exp_err);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wr = wr; v.kv = kv; v.kc = kc;
    v.chk_dout = chk_dout; v.exp_dout = exp_dout; v.exp_ready = exp_ready;
    v.exp_count = exp_count; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  int two_cnt;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive_cpu(16'h0000, 16'h0000, 1'b0);
    drive_kbd(1'b0, 16'h0000);
    drive_scr(1'b0, 13'h0000);

    // ---- reset state ----
    @(negedge clk);
    drive_cpu(16'h6000, 16'h0000, 1'b0);
    #1;
    check("rst_ack", 32'(bus.scr_ack_out), 0);
    check("rst_scr_data", 32'(bus.scr_data_out), 0);
    check("rst_err", 32'(bus.addr_err_out), 0);
    check("rst_count", 32'(bus.dbg_kbd_count), 0);
    check("rst_ready", 32'(bus.kbd_ready_out), 1);
    check("rst_kbd_read", 32'(bus.data_out), 0);
    check("rst_state", 32'(bus.dbg_scr_state), 32'(SCR_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // ---- table: RAM/screen, keyboard basics, illegal accesses ----
    two_cnt = (EFF_DEPTH > 1) ? 2 : 1;
    //      addr      wdata     wr kv kc      chk exp_dout  rdy                cnt          err
    add_vec(16'h4005, 16'hBEEF, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h0005, 16'h1234, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h0005, 16'h0000, 0, 0, 16'h0,  1, 16'h1234, 1,                 0,           0);
    add_vec(16'h4005, 16'h0000, 0, 0, 16'h0,  1, 16'hBEEF, 1,                 0,           0);
    add_vec(16'h6000, 16'h0000, 0, 1, 16'h41, 1, 16'h0000, 1,                 0,           0);
    add_vec(16'h6000, 16'h0000, 0, 1, 16'h42, 1, 16'h0041, EFF_DEPTH > 1,     1,           0);
    add_vec(16'h6000, 16'h0000, 0, 0, 16'h0,  1, 16'h0041, EFF_DEPTH > 2,     two_cnt,     0);
    add_vec(16'h6000, 16'hFFFF, 1, 0, 16'h0,  1, 16'h0041, EFF_DEPTH > 2,     two_cnt,     0);
    add_vec(16'h6000, 16'h0000, 0, 0, 16'h0,  1, (EFF_DEPTH > 1) ? 16'h0042 : 16'h0000, 1, two_cnt - 1, 0);
    add_vec(16'h6000, 16'hFFFF, 1, 0, 16'h0,  1, (EFF_DEPTH > 1) ? 16'h0042 : 16'h0000, 1, two_cnt - 1, 0);
    add_vec(16'h6000, 16'hFFFF, 1, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'h6000, 16'h0000, 0, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'h3000, 16'h0777, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h7000, 16'h9999, 1, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'h7000, 16'h0000, 0, 0, 16'h0,  1, 16'h0000, 1,                 0,           1);
    add_vec(16'h3000, 16'h0000, 0, 0, 16'h0,  1, 16'h0777, 1,                 0,           0);
    add_vec(16'h7005, 16'h9999, 1, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'h0005, 16'h0000, 0, 0, 16'h0,  1, 16'h1234, 1,                 0,           1);
    add_vec(16'h6001, 16'h0000, 0, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'hFFFF, 16'h0000, 0, 0, 16'h0,  1, 16'h0000, 1,                 0,           0);
    add_vec(16'h5FFF, 16'h5A5A, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h5FFF, 16'h0000, 0, 0, 16'h0,  1, 16'h5A5A, 1,                 0,           0);
    add_vec(16'h4000, 16'h0C0C, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h3FFF, 16'h3F3F, 1, 0, 16'h0,  0, 16'h0000, 1,                 0,           0);
    add_vec(16'h4000, 16'h0000, 0, 0, 16'h0,  1, 16'h0C0C, 1,                 0,           0);
    add_vec(16'h3FFF, 16'h0000, 0, 0, 16'h0,  1, 16'h3F3F, 1,                 0,           0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_cpu(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
      drive_kbd(vecs[i].kv, vecs[i].kc);
      #1;
      if (vecs[i].chk_dout)
        check($sformatf("vec%0d_dout", i), 32'(bus.data_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_ready", i), 32'(bus.kbd_ready_out), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_count", i), 32'(bus.dbg_kbd_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_err", i), 32'(bus.addr_err_out), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ack", i), 32'(bus.scr_ack_out), 0);
    end

    // ---- keyboard buffer fill, refused push, push+pop while full ----
    for (int i = 0; i < EFF_DEPTH; i++) begin
      @(negedge clk);
      drive_cpu(16'h6000, 16'h0000, 1'b0);
      drive_kbd(1'b1, 16'h0050 + 16'(i));
      #1;
      check($sformatf("fill%0d_ready", i), 32'(bus.kbd_ready_out), 1);
      check($sformatf("fill%0d_count", i), 32'(bus.dbg_kbd_count), 32'(i));
    end
    @(negedge clk);
    drive_kbd(1'b1, 16'h0099);
    #1;
    check("full_ready", 32'(bus.kbd_ready_out), 0);
    check("full_count", 32'(bus.dbg_kbd_count), 32'(EFF_DEPTH));
    check("full_head", 32'(bus.data_out), 32'h50);
    @(negedge clk);
    drive_kbd(1'b1, 16'h00AA);
    drive_cpu(16'h6000, 16'h0000, 1'b1);
    #1;
    check("refused_count", 32'(bus.dbg_kbd_count), 32'(EFF_DEPTH));
    check("refused_ready", 32'(bus.kbd_ready_out), 0);
    @(negedge clk);
    drive_kbd(1'b0, 16'h0000);
    drive_cpu(16'h6000, 16'h0000, 1'b0);
    #1;
    check("pushpop_count", 32'(bus.dbg_kbd_count), 32'(EFF_DEPTH - 1));
    check("pushpop_ready", 32'(bus.kbd_ready_out), 1);
    check("pushpop_head", 32'(bus.data_out), (EFF_DEPTH > 1) ? 32'h51 : 32'h0);
    for (int i = 1; i < EFF_DEPTH; i++) begin
      @(negedge clk);
      drive_cpu(16'h6000, 16'h0000, 1'b1);
      #1;
      check($sformatf("drain%0d_head", i), 32'(bus.data_out), 32'h50 + 32'(i));
    end
    @(negedge clk);
    drive_cpu(16'h6000, 16'h0000, 1'b0);
    #1;
    check("drained_count", 32'(bus.dbg_kbd_count), 0);
    check("drained_head", 32'(bus.data_out), 0);

    // ---- display read-before-write, busy requests ignored ----
    @(negedge clk);
    drive_cpu(16'h4010, 16'hAAAA, 1'b1);
    @(negedge clk);
    drive_cpu(16'h4010, 16'h5555, 1'b1);
    drive_scr(1'b1, 13'h0010);
    #1;
    check("scr_idle_ack", 32'(bus.scr_ack_out), 0);
    @(negedge clk);
    drive_cpu(16'h4010, 16'h0000, 1'b0);
    drive_scr(1'b1, 13'h0011);
    #1;
    check("scr_rbw_ack", 32'(bus.scr_ack_out), 1);
    check("scr_rbw_data", 32'(bus.scr_data_out), 32'hAAAA);
    check("scr_busy_state", 32'(bus.dbg_scr_state), 32'(SCR_BUSY));
    check("scr_cpu_new", 32'(bus.data_out), 32'h5555);
    @(negedge clk);
    drive_scr(1'b1, 13'h0010);
    #1;
    check("scr_busy_ignored", 32'(bus.scr_ack_out), 0);
    @(negedge clk);
    drive_scr(1'b0, 13'h0000);
    #1;
    check("scr_rereq_ack", 32'(bus.scr_ack_out), 1);
    check("scr_rereq_data", 32'(bus.scr_data_out), 32'h5555);
    @(negedge clk);
    #1;
    check("scr_one_cycle", 32'(bus.scr_ack_out), 0);

    // ---- reset during BUSY ----
    @(negedge clk);
    drive_kbd(1'b1, 16'h0033);
    drive_scr(1'b1, 13'h0010);
    drive_cpu(16'h6000, 16'h0000, 1'b0);
    @(negedge clk);
    drive_kbd(1'b0, 16'h0000);
    drive_scr(1'b0, 13'h0000);
    #1;
    check("pre_rst_ack", 32'(bus.scr_ack_out), 1);
    check("pre_rst_count", 32'(bus.dbg_kbd_count), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", 32'(bus.scr_ack_out), 0);
    check("midrst_state", 32'(bus.dbg_scr_state), 32'(SCR_IDLE));
    check("midrst_scr_data", 32'(bus.scr_data_out), 0);
    check("midrst_count", 32'(bus.dbg_kbd_count), 0);
    check("midrst_ready", 32'(bus.kbd_ready_out), 1);
    check("midrst_kbd_read", 32'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b0;
    drive_cpu(16'h0005, 16'h0000, 1'b0);
    #1;
    check("post_rst_ram_kept", 32'(bus.data_out), 32'h1234);
    @(negedge clk);
    drive_cpu(16'h6000, 16'h0000, 1'b0);
    #1;
    check("post_rst_no_ack", 32'(bus.scr_ack_out), 0);
    check("post_rst_kbd_read", 32'(bus.data_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hack_memory.md
HACK_MEMORY -- requirements
Module: hack_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 16, CPU address width.
REQ-003 The block SHALL have parameter KBD_DEPTH, default 4, keyboard FIFO entries, power of two.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port addr_in, input, ADDRESS_WIDTH, CPU data address.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH, CPU write data.
REQ-008 The block SHALL have port write_in, input, 1, CPU write strobe.
REQ-009 The block SHALL have port data_out, output, DATA_WIDTH, CPU read data.
REQ-010 The block SHALL have port kbd_valid_in, input, 1, keycode offered.
REQ-011 The block SHALL have port kbd_code_in, input, DATA_WIDTH, keycode.
REQ-012 The block SHALL have port kbd_ready_out, output, 1, FIFO can accept.
REQ-013 The block SHALL have port scr_req_in, input, 1, display read request.
REQ-014 The block SHALL have port scr_addr_in, input, 13, screen word index.
REQ-015 The block SHALL have port scr_ack_out, output, 1, display data valid.
REQ-016 The block SHALL have port scr_data_out, output, DATA_WIDTH, display read data.
REQ-017 The block SHALL have port addr_err_out, output, 1, illegal access flag.

Function
REQ-018 The map SHALL be: 0x0000-0x3FFF RAM (16K words); 0x4000-0x5FFF SCREEN (8K words); 0x6000 KBD; 0x6001-0xFFFF ILLEGAL.
REQ-019 data_out SHALL be a combinational function of addr_in and current state, with zero-cycle read latency.
REQ-020 A RAM or SCREEN write SHALL occur on the rising edge when write_in=1, and SHALL be visible on data_out the next cycle.
REQ-021 KBD reads SHALL return the FIFO head, or 0 when the FIFO is empty; reads SHALL NOT pop.
REQ-022 A write to 0x6000 SHALL pop one entry, ignore data_in, and have no effect when the FIFO is empty.
REQ-023 kbd_ready_out SHALL be 1 iff the FIFO is not full; a push SHALL occur when kbd_valid_in=1 and kbd_ready_out=1.
REQ-024 A simultaneous push and pop SHALL keep the count unchanged; on a full FIFO the pop SHALL proceed and the push SHALL be refused that cycle.
REQ-025 FIFO pointers SHALL wrap modulo KBD_DEPTH.
REQ-026 ILLEGAL reads SHALL return 0, and ILLEGAL writes SHALL be discarded.
REQ-027 addr_err_out SHALL be registered and pulse 1 for exactly the cycle after an ILLEGAL write.
REQ-028 The display port SHALL use the FSM IDLE->BUSY->IDLE: a request in IDLE with scr_req_in=1 captures scr_addr_in; the next cycle (BUSY) SHALL assert scr_ack_out=1 with scr_data_out valid for one cycle; requests during BUSY SHALL be ignored.
REQ-029 A display read and a CPU write to the same screen word in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-030 Reset SHALL clear the FIFO pointers and count, set FSM=IDLE, and clear scr_ack_out, scr_data_out and addr_err_out to 0.
REQ-031 RAM and SCREEN contents SHALL NOT be reset.
REQ-032 Reset asserted mid-request SHALL abort the request with no ack.

Configuration
REQ-033 With HACK_MEM_KBD_FIFO_EN defined, the keyboard buffer SHALL be a KBD_DEPTH-entry FIFO.
REQ-034 With HACK_MEM_KBD_FIFO_EN undefined, the keyboard buffer SHALL be a single holding register (full/empty flag) obeying the same push, pop and read rules.

Structure
REQ-035 Package hack_mem_pkg SHALL hold the region base/limit constants, the region enum (RAM, SCREEN, KBD, ILLEGAL) and the display FSM state enum.
REQ-036 The FIFO SHALL be the sub-module hack_kbd_fifo; decode and arrays SHALL remain in hack_memory.

Verification
REQ-037 Test 1: write 0x1234 to 0x0005, then read 0x0005 -> data_out=0x1234 the next cycle; read 0x4005 returns screen content, not 0x1234.
REQ-038 Test 2: push keycodes 0x41, 0x42 and read 0x6000 -> 0x41; write 0x6000 then read -> 0x42; pop twice -> 0x0000, with the second pop harmless.
REQ-039 Test 3: push 4 codes -> kbd_ready_out=0, and a 5th push is refused; push and pop in the same cycle while full -> count 3, ready=1.
REQ-040 Test 4: write to 0x7000 -> addr_err_out=1 for one cycle; read 0x7000 -> 0; RAM is unchanged.
REQ-041 Test 5: screen word 0x0010=0xAAAA; in the same cycle scr_req_in=1 at index 0x10 and the CPU writes 0x5555 to 0x4010 -> next cycle scr_ack_out=1 with scr_data_out=0xAAAA; a re-request yields 0x5555.
REQ-042 Test 6: assert rst during BUSY -> no ack, the FIFO is empty, and a read of 0x6000 returns 0.
